pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (legal 8..64, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operation offered.
REQ-006 The block SHALL have port in_ready, output, 1, operation can be accepted.
REQ-007 The block SHALL have port ctrl, input, 4, opcode.
REQ-008 The block SHALL have ports x and y, input, WIDTH each, operands.
REQ-009 The block SHALL have port out_valid, output, 1, result available.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 The block SHALL have port out, output, WIDTH, registered result.
REQ-012 The block SHALL have ports carry and zero, output, 1 each, registered flags.

Function
REQ-013 The block SHALL accept an operation on a rising edge where in_valid && in_ready, capturing ctrl, x and y.
REQ-014 The block SHALL decode opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sltu, 0101 xor, 0110 nor, 0111 sll (y << x[SHW-1:0]), 1000 srl, 1001 sra (sign-extends y[WIDTH-1]), 1010 slt signed, 1011 mul low half, 1100 mulhu (unsigned high half), 1101 divu, 1110 remu, 1111 result 0.
REQ-015 The block SHALL ignore bits of x above SHW for shifts.
REQ-016 The block SHALL set carry to bit WIDTH of {0,x}+{0,y} for add and of {0,x}+{0,~y}+1 for sub, and to 0 for all other opcodes.
REQ-017 The block SHALL set zero to (out == 0) for every opcode.
REQ-018 The block SHALL run a three-state FSM: IDLE, BUSY, DONE.
REQ-019 On accepting opcodes 0000-1010 or 1111, the FSM SHALL go IDLE->DONE and register the result, so out_valid rises one edge after acceptance.
REQ-020 On accepting opcodes 1011-1110, the FSM SHALL go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles (shift-add multiply, restoring divide), then go to DONE, so out_valid rises WIDTH+1 edges after acceptance.
REQ-021 Division by zero SHALL complete in normal latency with quotient all-ones and remainder = x.
REQ-022 While out_valid && !out_ready, the block SHALL hold out, carry and zero stable.
REQ-023 DONE SHALL go to IDLE on out_ready when in_valid is low.
REQ-024 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), allowing back-to-back single-cycle ops at one result per cycle.
REQ-025 Simultaneous out_ready and acceptance in DONE SHALL retire the old result and start the new op on the same edge.
REQ-026 in_ready SHALL be 0 throughout BUSY; in_valid during BUSY SHALL have no effect.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state=IDLE, out_valid=0, out=0, carry=0, zero=0, iteration counter=0, regardless of the clock.
REQ-028 Reset during BUSY or DONE SHALL abort the operation with no result emitted after release.
REQ-029 in_ready SHALL be 1 from the first edge after reset release.

Structure
REQ-030 Opcode constants and the FSM state enum SHALL live in shared package alu_pkg.
REQ-031 The iterative multiply/divide datapath SHALL be sub-module alu_muldiv (start, op, operands in; done, result out); combinational ops stay in pipe_alu.

Verification
REQ-032 WIDTH=32, add x=FFFFFFFF y=00000001 -> out_valid next edge, out=0, carry=1, zero=1.
REQ-033 sra x=4 y=80000000 -> out=F8000000; sra x=36 (SHW truncation, amount 4) -> same result.
REQ-034 mulhu x=FFFFFFFF y=FFFFFFFF -> out_valid exactly 33 edges after acceptance, out=FFFFFFFE, in_ready low meanwhile.
REQ-035 divu x=7 y=0 -> out=FFFFFFFF; remu x=7 y=0 -> out=7.
REQ-036 Stream of 8 add ops with out_ready held low for 3 cycles mid-stream -> results in order, out stable while stalled, no op lost or duplicated.
REQ-037 rst_n asserted 10 cycles into divu -> out_valid=0 immediately, no result after release, next add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, FSM states
// and small decode helpers used by both the top level and the mul/div unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_NOR   = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;
  localparam logic [3:0] OP_ZERO  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes that go through the bit-serial multiply/divide unit
  function automatic logic isIterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Multiply-family opcodes; everything else iterative is a divide
  function automatic logic isMultiply(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Bit-serial multiply / restoring divide unit. Operands are loaded on
// i_start; one bit is processed per cycle for WIDTH cycles. o_done is raised
// during the final iteration cycle and o_result carries the value that the
// final iteration produces, so the caller can capture it on that same edge.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam logic [SHW:0] LAST_STEP = (SHW + 1)'(WIDTH - 1);

  logic             r_busy;
  logic [SHW:0]     r_count;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;

  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divDiff;
  logic [WIDTH-1:0] w_nextHi;
  logic [WIDTH-1:0] w_nextLo;
  logic             w_lastStep;

  assign w_lastStep = (r_count == LAST_STEP);
  assign o_done     = r_busy && w_lastStep;

  // One iteration step: {hi,lo} is the running product for multiply, or
  // {remainder,quotient-in-progress} for divide. A zero divisor naturally
  // yields an all-ones quotient and leaves the dividend as the remainder.
  always_comb begin
    w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_divShift = {r_hi, r_lo[WIDTH-1]};
    w_divDiff  = w_divShift - {1'b0, r_opnd};
    w_nextHi   = r_hi;
    w_nextLo   = r_lo;
    if (isMultiply(r_op)) begin
      w_nextHi = w_mulSum[WIDTH:1];
      w_nextLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
    end else if (!w_divDiff[WIDTH]) begin
      w_nextHi = w_divDiff[WIDTH-1:0];
      w_nextLo = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_nextHi = w_divShift[WIDTH-1:0];
      w_nextLo = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Pick the half of the final state that the opcode asks for
  always_comb begin
    o_result = '0;
    case (r_op)
      OP_MUL:   o_result = w_nextLo;
      OP_MULHU: o_result = w_nextHi;
      OP_DIVU:  o_result = w_nextLo;
      OP_REMU:  o_result = w_nextHi;
      default:  o_result = '0;
    endcase
  end

  // Load operands on start, then step once per cycle until the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_op    <= i_op;
      r_hi    <= '0;
      r_lo    <= i_x;
      r_opnd  <= i_y;
    end else if (r_busy) begin
      r_hi    <= w_nextHi;
      r_lo    <= w_nextLo;
      r_count <= r_count + 1'b1;
      if (w_lastStep) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Pipelined ALU with valid/ready handshakes on both sides. Single-cycle
// operations complete on the acceptance edge; multiply/divide operations are
// handed to alu_muldiv and complete WIDTH cycles later. The result, carry and
// zero registers hold steady while the consumer stalls.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_zero;

  logic             w_accept;
  logic             w_startIter;
  logic             w_iterDone;
  logic [WIDTH-1:0] w_iterResult;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluCarry;
  logic [WIDTH:0]   w_addSum;
  logic [WIDTH:0]   w_subSum;
  logic [SHW-1:0]   w_shamt;

  assign w_shamt  = x[SHW-1:0];
  assign w_addSum = {1'b0, x} + {1'b0, y};
  assign w_subSum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};

  alu_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_startIter),
    .i_op     (ctrl),
    .i_x      (x),
    .i_y      (y),
    .o_done   (w_iterDone),
    .o_result (w_iterResult)
  );

  // Single-cycle datapath; carry only has meaning for add and subtract
  always_comb begin
    w_aluResult = '0;
    w_aluCarry  = 1'b0;
    case (ctrl)
      OP_ADD: begin
        w_aluResult = w_addSum[WIDTH-1:0];
        w_aluCarry  = w_addSum[WIDTH];
      end
      OP_SUB: begin
        w_aluResult = w_subSum[WIDTH-1:0];
        w_aluCarry  = w_subSum[WIDTH];
      end
      OP_AND:  w_aluResult = x & y;
      OP_OR:   w_aluResult = x | y;
      OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_XOR:  w_aluResult = x ^ y;
      OP_NOR:  w_aluResult = ~(x | y);
      OP_SLL:  w_aluResult = y << w_shamt;
      OP_SRL:  w_aluResult = y >> w_shamt;
      OP_SRA:  w_aluResult = $signed(y) >>> w_shamt;
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: w_aluResult = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; DONE can chain directly into a new op when the
  // current result is taken on the same edge
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = isIterative(ctrl) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_iterDone) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_nextState = isIterative(ctrl) ? ST_BUSY : ST_DONE;
        end else if (out_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs derived from the current state
  always_comb begin
    in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    out_valid   = (r_state == ST_DONE);
    w_accept    = in_valid && in_ready;
    w_startIter = w_accept && isIterative(ctrl);
  end

  // Result registers: capture single-cycle results on acceptance and
  // iterative results when the mul/div unit finishes; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept && !isIterative(ctrl)) begin
      r_out   <= w_aluResult;
      r_carry <= w_aluCarry;
      r_zero  <= (w_aluResult == '0);
    end else if (w_iterDone) begin
      r_out   <= w_iterResult;
      r_carry <= 1'b0;
      r_zero  <= (w_iterResult == '0);
    end
  end

  assign out   = r_out;
  assign carry = r_carry;
  assign zero  = r_zero;

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu: directed corner cases, a stalled
// back-to-back stream, a reset abort mid-divide and randomized single ops,
// all compared against an arithmetic reference model.
module tb_pipe_alu;

  localparam int W = 32;

  localparam logic [3:0] T_ADD   = 4'h0;
  localparam logic [3:0] T_SUB   = 4'h1;
  localparam logic [3:0] T_SRA   = 4'h9;
  localparam logic [3:0] T_SLT   = 4'hA;
  localparam logic [3:0] T_MUL   = 4'hB;
  localparam logic [3:0] T_MULHU = 4'hC;
  localparam logic [3:0] T_DIVU  = 4'hD;
  localparam logic [3:0] T_REMU  = 4'hE;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctrl;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;

  int total = 0;
  int bad   = 0;

  pipe_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design cannot hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from plain arithmetic on the operands
  function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic c);
    logic [63:0] p;
    int          amt;
    p   = 64'(a) * 64'(b);
    amt = int'(a % 32);
    c   = 1'b0;
    r   = '0;
    case (op)
      4'h0: begin r = a + b; c = ((64'(a) + 64'(b)) > 64'hFFFF_FFFF); end
      4'h1: begin r = a - b; c = (a >= b); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = (a < b) ? 32'd1 : 32'd0;
      4'h5: r = a ^ b;
      4'h6: r = ~(a | b);
      4'h7: r = b << amt;
      4'h8: r = b >> amt;
      4'h9: r = $signed(b) >>> amt;
      4'hA: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hB: r = p[31:0];
      4'hC: r = p[63:32];
      4'hD: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hE: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
  endfunction

  // One isolated operation: offer, measure latency, check result, stall, retire
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] expR;
    logic         expC;
    logic         iter;
    int           edges;
    int           readyHigh;
    refModel(op, a, b, expR, expC);
    iter      = (op >= 4'hB) && (op <= 4'hE);
    in_valid  = 1'b1;
    ctrl      = op;
    x         = a;
    y         = b;
    out_ready = 1'b0;
    #1;
    checkOutput("offerRdy", in_ready, 1);
    tick();
    edges     = 1;
    readyHigh = 0;
    in_valid  = iter;
    ctrl      = 4'($urandom_range(0, 15));
    x         = $urandom;
    y         = $urandom;
    #1;
    while (!out_valid && edges < 40) begin
      if (in_ready) readyHigh++;
      tick();
      edges++;
    end
    in_valid = 1'b0;
    checkOutput("latency", edges, iter ? (W + 1) : 1);
    if (iter) checkOutput("busyRdy", readyHigh, 0);
    checkOutput("result", out, expR);
    checkOutput("carry", carry, expC);
    checkOutput("zero", zero, (expR == 0));
    tick();
    checkOutput("holdOut", {carry, zero, out}, {expC, (expR == 0), expR});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("retired", out_valid, 0);
  endtask

  // Back-to-back adds with a three-cycle consumer stall in the middle
  task automatic runStream();
    logic [W:0]   expQ[$];
    logic [W:0]   held;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         stalled;
    int           sent;
    int           got;
    int           cyc;
    sent    = 0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    a       = $urandom;
    b       = $urandom;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 8);
      ctrl      = T_ADD;
      x         = a;
      y         = b;
      #1;
      if (stalled) checkOutput("stallHold", {carry, out}, held);
      if (out_valid && out_ready) begin
        checkOutput("strmOrder", (got < sent), 1);
        if (expQ.size() > 0) checkOutput("strmData", {carry, out}, expQ.pop_front());
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {carry, out};
      if (in_valid && in_ready) begin
        refModel(T_ADD, a, b, r, c);
        expQ.push_back({c, r});
        sent++;
        a = $urandom;
        b = $urandom;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("strmSent", sent, 8);
    checkOutput("strmGot", got, 8);
    checkOutput("strmIdle", out_valid, 0);
  endtask

  // Reset asserted in the middle of a divide must discard it
  task automatic runResetAbort();
    int highs;
    highs    = 0;
    in_valid = 1'b1;
    ctrl     = T_DIVU;
    x        = $urandom;
    y        = 32'd3;
    #1;
    checkOutput("abOffer", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checkOutput("abBusy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abValid", out_valid, 0);
    checkOutput("abOut", out, 0);
    checkOutput("abFlags", {carry, zero}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abRdy", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) highs++;
      tick();
    end
    checkOutput("abNoResult", highs, 0);
    applyStimulus(T_ADD, 32'd100, 32'd23);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ctrl      = '0;
    x         = '0;
    y         = '0;
    out_ready = 1'b0;
    #1;
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstOut", out, 0);
    checkOutput("rstFlags", {carry, zero}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rstRdy", in_ready, 1);

    applyStimulus(T_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(T_SRA, 32'd4, 32'h8000_0000);
    applyStimulus(T_SRA, 32'd36, 32'h8000_0000);
    applyStimulus(T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(T_DIVU, 32'd7, 32'd0);
    applyStimulus(T_REMU, 32'd7, 32'd0);
    applyStimulus(T_SUB, 32'd5, 32'd5);
    applyStimulus(T_SUB, 32'd0, 32'd1);
    applyStimulus(T_SLT, 32'h8000_0000, 32'd1);

    runStream();
    runResetAbort();

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
